// File: rtl/xbar_pkg.sv
// rtl/xbar_pkg.sv - shared types, default widths and address decode for the req/ack/resp crossbar
package xbar_pkg;

  typedef enum logic {
    CMD_READ  = 1'b0,
    CMD_WRITE = 1'b1
  } cmd_e;

  localparam int XBAR_N_MASTERS  = 4;
  localparam int XBAR_N_SLAVES   = 4;
  localparam int XBAR_ADDR_WIDTH = 32;
  localparam int XBAR_DATA_WIDTH = 32;
  localparam int XBAR_RESP_DEPTH = 4;

  // Target slave is the top sel_bits of the address.
  function automatic int unsigned slave_sel(input logic [63:0] addr,
                                            input int unsigned addr_width,
                                            input int unsigned sel_bits);
    logic [63:0] shifted;
    shifted = addr >> (addr_width - sel_bits);
    return 32'(shifted) & ((32'd1 << sel_bits) - 32'd1);
  endfunction

endpackage

// File: rtl/xbar_rr_arbiter.sv
// rtl/xbar_rr_arbiter.sv - round-robin arbiter, one-hot grant held while the slave stalls
module xbar_rr_arbiter #(
  parameter int N = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req,
  input  logic                 ack,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_idx
);

  localparam int IDX_W = $clog2(N);

  logic [IDX_W-1:0] ptr_q;
  logic             lock_q;
  logic [N-1:0]     lock_gnt_q;
  logic [IDX_W-1:0] lock_idx_q;
  logic [N-1:0]     rr_gnt;
  logic [IDX_W-1:0] rr_idx;

  always_comb begin
    int   idx;
    logic found;
    rr_gnt = '0;
    rr_idx = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr_q) + k) % N;
      if (!found && req[idx]) begin
        found       = 1'b1;
        rr_gnt[idx] = 1'b1;
        rr_idx      = IDX_W'(idx);
      end
    end
  end

  // A stalled grant is frozen so a newly arriving master cannot steal the slave mid-handshake.
  always_comb begin
    gnt     = lock_q ? (lock_gnt_q & req) : rr_gnt;
    gnt_idx = lock_q ? lock_idx_q : rr_idx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q      <= '0;
      lock_q     <= 1'b0;
      lock_gnt_q <= '0;
      lock_idx_q <= '0;
    end else if (|gnt) begin
      if (ack) begin
        ptr_q  <= (gnt_idx == IDX_W'(N - 1)) ? '0 : gnt_idx + IDX_W'(1);
        lock_q <= 1'b0;
      end else begin
        lock_q     <= 1'b1;
        lock_gnt_q <= gnt;
        lock_idx_q <= gnt_idx;
      end
    end else begin
      lock_q <= 1'b0;
    end
  end

endmodule

// File: rtl/xbar_rr_nxm.sv
// rtl/xbar_rr_nxm.sv - N x M req/ack/resp crossbar with per-slave RR and in-order read return
// Optional XBAR_WR_RESP_EN: writes are tracked and answered like reads.
module xbar_rr_nxm
  import xbar_pkg::*;
#(
  parameter int N_MASTERS  = XBAR_N_MASTERS,
  parameter int N_SLAVES   = XBAR_N_SLAVES,
  parameter int ADDR_WIDTH = XBAR_ADDR_WIDTH,
  parameter int DATA_WIDTH = XBAR_DATA_WIDTH,
  parameter int RESP_DEPTH = XBAR_RESP_DEPTH
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [N_MASTERS-1:0]                  m_req,
  input  logic [N_MASTERS-1:0][ADDR_WIDTH-1:0]  m_addr,
  input  logic [N_MASTERS-1:0]                  m_cmd,
  input  logic [N_MASTERS-1:0][DATA_WIDTH-1:0]  m_wdata,
  output logic [N_MASTERS-1:0]                  m_ack,
  output logic [N_MASTERS-1:0][DATA_WIDTH-1:0]  m_rdata,
  output logic [N_MASTERS-1:0]                  m_resp,
  output logic [N_SLAVES-1:0]                   s_req,
  output logic [N_SLAVES-1:0][ADDR_WIDTH-1:0]   s_addr,
  output logic [N_SLAVES-1:0]                   s_cmd,
  output logic [N_SLAVES-1:0][DATA_WIDTH-1:0]   s_wdata,
  input  logic [N_SLAVES-1:0]                   s_ack,
  input  logic [N_SLAVES-1:0][DATA_WIDTH-1:0]   s_rdata,
  input  logic [N_SLAVES-1:0]                   s_resp
);

  localparam int SEL_W  = $clog2(N_SLAVES);
  localparam int MID_W  = $clog2(N_MASTERS);
  localparam int PTR_W  = $clog2(RESP_DEPTH);
  localparam int FCNT_W = PTR_W + 1;
  localparam int CNT_W  = $clog2(N_SLAVES * RESP_DEPTH) + 1;

  logic [N_MASTERS-1:0][SEL_W-1:0] m_sel;
  logic [N_MASTERS-1:0]            m_tracked;
  logic [N_MASTERS-1:0]            m_order_ok;
  logic [N_MASTERS-1:0][CNT_W-1:0] out_cnt;
  logic [N_MASTERS-1:0][SEL_W-1:0] last_sel;
  logic [N_MASTERS-1:0]            cnt_inc;

  logic [N_MASTERS-1:0] elig    [N_SLAVES];
  logic [N_MASTERS-1:0] gnt     [N_SLAVES];
  logic [MID_W-1:0]     gnt_idx [N_SLAVES];

  logic [MID_W-1:0]  fifo_mem [N_SLAVES][RESP_DEPTH];
  logic [PTR_W-1:0]  fifo_wp  [N_SLAVES];
  logic [PTR_W-1:0]  fifo_rp  [N_SLAVES];
  logic [FCNT_W-1:0] fifo_cnt [N_SLAVES];
  logic [N_SLAVES-1:0] fifo_full, fifo_push, fifo_pop;

  // Eligibility; rst_n gating forces every combinational output to 0 while reset is held.
  always_comb begin
    for (int j = 0; j < N_SLAVES; j++) begin
      fifo_full[j] = (fifo_cnt[j] == FCNT_W'(RESP_DEPTH));
    end
    for (int i = 0; i < N_MASTERS; i++) begin
      m_sel[i] = SEL_W'(slave_sel(64'(m_addr[i]), ADDR_WIDTH, SEL_W));
`ifdef XBAR_WR_RESP_EN
      m_tracked[i] = 1'b1;
`else
      m_tracked[i] = (cmd_e'(m_cmd[i]) == CMD_READ);
`endif
      m_order_ok[i] = (out_cnt[i] == '0) || (last_sel[i] == m_sel[i]);
    end
    for (int j = 0; j < N_SLAVES; j++) begin
      for (int i = 0; i < N_MASTERS; i++) begin
        elig[j][i] = rst_n && m_req[i] && (m_sel[i] == SEL_W'(j)) &&
                     (!m_tracked[i] || (!fifo_full[j] && m_order_ok[i]));
      end
    end
  end

  for (genvar gj = 0; gj < N_SLAVES; gj++) begin : g_arb
    xbar_rr_arbiter #(.N(N_MASTERS)) u_arb (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (elig[gj]),
      .ack     (s_ack[gj]),
      .gnt     (gnt[gj]),
      .gnt_idx (gnt_idx[gj])
    );
  end

  always_comb begin
    logic [MID_W-1:0] head;
    s_req     = '0;
    s_addr    = '0;
    s_cmd     = '0;
    s_wdata   = '0;
    m_ack     = '0;
    m_resp    = '0;
    m_rdata   = '0;
    fifo_push = '0;
    fifo_pop  = '0;
    cnt_inc   = '0;
    head      = '0;
    for (int j = 0; j < N_SLAVES; j++) begin
      s_req[j] = |gnt[j];
      for (int i = 0; i < N_MASTERS; i++) begin
        if (gnt[j][i]) begin
          s_addr[j]  = m_addr[i];
          s_cmd[j]   = m_cmd[i];
          s_wdata[j] = m_wdata[i];
          m_ack[i]   = s_ack[j];
          if (s_ack[j] && m_tracked[i]) begin
            fifo_push[j] = 1'b1;
            cnt_inc[i]   = 1'b1;
          end
        end
      end
      // Ordering rule guarantees at most one slave returns to a given master per cycle.
      fifo_pop[j] = s_resp[j] && (fifo_cnt[j] != '0);
      head        = fifo_mem[j][fifo_rp[j]];
      for (int i = 0; i < N_MASTERS; i++) begin
        if (fifo_pop[j] && head == MID_W'(i)) begin
          m_resp[i]  = 1'b1;
          m_rdata[i] = s_rdata[j];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int j = 0; j < N_SLAVES; j++) begin
      if (fifo_push[j]) fifo_mem[j][fifo_wp[j]] <= gnt_idx[j];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < N_SLAVES; j++) begin
        fifo_wp[j]  <= '0;
        fifo_rp[j]  <= '0;
        fifo_cnt[j] <= '0;
      end
      out_cnt  <= '0;
      last_sel <= '0;
    end else begin
      for (int j = 0; j < N_SLAVES; j++) begin
        if (fifo_push[j]) fifo_wp[j] <= fifo_wp[j] + PTR_W'(1);
        if (fifo_pop[j])  fifo_rp[j] <= fifo_rp[j] + PTR_W'(1);
        case ({fifo_push[j], fifo_pop[j]})
          2'b10:   fifo_cnt[j] <= fifo_cnt[j] + FCNT_W'(1);
          2'b01:   fifo_cnt[j] <= fifo_cnt[j] - FCNT_W'(1);
          default: ;
        endcase
      end
      for (int i = 0; i < N_MASTERS; i++) begin
        case ({cnt_inc[i], m_resp[i]})
          2'b10:   out_cnt[i] <= out_cnt[i] + CNT_W'(1);
          2'b01:   out_cnt[i] <= out_cnt[i] - CNT_W'(1);
          default: ;
        endcase
        if (cnt_inc[i]) last_sel[i] <= m_sel[i];
      end
    end
  end

  for (genvar gj = 0; gj < N_SLAVES; gj++) begin : g_chk_s
    a_resp_on_empty: assert property (@(posedge clk) disable iff (!rst_n)
      !(s_resp[gj] && fifo_cnt[gj] == '0));
  end

  for (genvar gi = 0; gi < N_MASTERS; gi++) begin : g_chk_m
    a_req_held: assert property (@(posedge clk) disable iff (!rst_n)
      (m_req[gi] && !m_ack[gi]) |=> m_req[gi]);
  end

endmodule

// File: tb/tb_xbar_rr_nxm.sv
// tb/tb_xbar_rr_nxm.sv - directed scoreboard bench for xbar_rr_nxm (default build)
module tb_xbar_rr_nxm;
  import xbar_pkg::*;

  localparam int NM = 4;
  localparam int NS = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int RD = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NM-1:0]         m_req = '0;
  logic [NM-1:0][AW-1:0] m_addr = '0;
  logic [NM-1:0]         m_cmd = '0;
  logic [NM-1:0][DW-1:0] m_wdata = '0;
  logic [NM-1:0]         m_ack;
  logic [NM-1:0][DW-1:0] m_rdata;
  logic [NM-1:0]         m_resp;
  logic [NS-1:0]         s_req;
  logic [NS-1:0][AW-1:0] s_addr;
  logic [NS-1:0]         s_cmd;
  logic [NS-1:0][DW-1:0] s_wdata;
  logic [NS-1:0]         s_ack = '0;
  logic [NS-1:0][DW-1:0] s_rdata = '0;
  logic [NS-1:0]         s_resp = '0;

  xbar_rr_nxm #(
    .N_MASTERS(NM), .N_SLAVES(NS), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RESP_DEPTH(RD)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .m_req(m_req), .m_addr(m_addr), .m_cmd(m_cmd), .m_wdata(m_wdata),
    .m_ack(m_ack), .m_rdata(m_rdata), .m_resp(m_resp),
    .s_req(s_req), .s_addr(s_addr), .s_cmd(s_cmd), .s_wdata(s_wdata),
    .s_ack(s_ack), .s_rdata(s_rdata), .s_resp(s_resp)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] exp_q [NM][$];
  logic [DW-1:0] pend  [NS][$];
  int            grant_q[$];
  bit            chk_grant = 1'b0;
  bit            resp_en [NS] = '{1'b1, 1'b1, 1'b1, 1'b1};
  int            ack_lat [NS] = '{0, 0, 0, 0};
  int            wait_cnt[NS] = '{0, 0, 0, 0};

  // Slave read data is a fixed function of the address; 0x10 maps to 0xDEAD.
  function automatic logic [DW-1:0] rdata_of(input logic [AW-1:0] a);
    return a ^ 32'h0000_DEBD;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic flag_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got event expected none", name);
  endtask

  // Slave model: ack after ack_lat stalled cycles, return read data in acceptance order.
  always begin
    @(posedge clk);
    #2;
    for (int j = 0; j < NS; j++) begin
      s_ack[j]   = s_req[j] && (wait_cnt[j] >= ack_lat[j]);
      s_resp[j]  = resp_en[j] && (pend[j].size() > 0);
      s_rdata[j] = s_resp[j] ? pend[j][0] : '0;
    end
  end

  // Monitor: records slave transfers and scores master responses and grant order.
  always @(negedge clk) begin
    if (!rst_n) begin
      for (int j = 0; j < NS; j++) begin
        wait_cnt[j] = 0;
        pend[j].delete();
      end
    end else begin
      for (int j = 0; j < NS; j++) begin
        if (s_req[j] && s_ack[j]) begin
          wait_cnt[j] = 0;
          if (!s_cmd[j]) pend[j].push_back(rdata_of(s_addr[j]));
          if (chk_grant && j == 1) begin
            if (grant_q.size() == 0) flag_fail("grant_extra");
            else check("grant_order", 128'(m_ack), 128'(1) << grant_q.pop_front());
          end
        end else if (s_req[j]) begin
          wait_cnt[j]++;
        end
        if (s_resp[j] && pend[j].size() > 0) void'(pend[j].pop_front());
      end
      for (int m = 0; m < NM; m++) begin
        if (m_resp[m]) begin
          if (exp_q[m].size() == 0) flag_fail($sformatf("resp_unexpected_m%0d", m));
          else check($sformatf("resp_data_m%0d", m), 128'(m_rdata[m]), 128'(exp_q[m].pop_front()));
        end
      end
    end
  end

  task automatic start_req(input int m, input logic [AW-1:0] a, input logic c, input logic [DW-1:0] wd);
    m_addr[m]  = a;
    m_cmd[m]   = c;
    m_wdata[m] = wd;
    m_req[m]   = 1'b1;
  endtask

  task automatic wait_ack(input int m, input int budget);
    int n = 0;
    bit ok = 1'b0;
    while (n < budget) begin
      @(negedge clk);
      n++;
      if (m_ack[m]) begin
        ok = 1'b1;
        break;
      end
    end
    check($sformatf("ack_m%0d_%0h", m, m_addr[m]), 128'(ok), 128'(1));
    if (ok && !m_cmd[m]) exp_q[m].push_back(rdata_of(m_addr[m]));
    @(posedge clk);
    #1;
    m_req[m] = 1'b0;
  endtask

  task automatic master_xfer(input int m, input logic [AW-1:0] a, input logic c, input logic [DW-1:0] wd);
    start_req(m, a, c, wd);
    wait_ack(m, 20);
  endtask

  task automatic burst(input int m);
    for (int k = 0; k < 2; k++) master_xfer(m, 32'h4000_0000 | AW'(m << 8) | AW'(k << 4), 1'b0, '0);
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    int left;
    left = 0;
    for (int m = 0; m < NM; m++) left += exp_q[m].size();
    while (left > 0 && n < budget) begin
      @(negedge clk);
      n++;
      left = 0;
      for (int m = 0; m < NM; m++) left += exp_q[m].size();
    end
    check("drain", 128'(left), 128'(0));
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit seen;
    // Reset state, including a live request that must not leak through.
    repeat (2) @(posedge clk);
    #1;
    start_req(0, 32'h0000_0010, 1'b0, '0);
    #1;
    check("rst_s_req", 128'(s_req), 128'(0));
    check("rst_m_ack", 128'(m_ack), 128'(0));
    check("rst_m_resp", 128'(m_resp), 128'(0));
    check("rst_s_addr", 128'(s_addr), 128'(0));
    check("rst_m_rdata", 128'(m_rdata), 128'(0));
    m_req = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single read, slave acks one cycle late.
    ack_lat[0] = 1;
    start_req(0, 32'h0000_0010, 1'b0, '0);
    @(negedge clk);
    check("t1_s_req", 128'(s_req), 128'(4'b0001));
    check("t1_s_addr", 128'(s_addr[0]), 128'(32'h0000_0010));
    check("t1_no_ack", 128'(m_ack), 128'(0));
    @(negedge clk);
    check("t1_ack", 128'(m_ack), 128'(4'b0001));
    exp_q[0].push_back(32'h0000_DEAD);
    @(posedge clk);
    #1;
    m_req[0] = 1'b0;
    ack_lat[0] = 0;
    wait_drain(20);

    // All masters hammer slave 1: strict rotation.
    grant_q = '{0, 1, 2, 3, 0, 1, 2, 3};
    chk_grant = 1'b1;
    fork
      burst(0);
      burst(1);
      burst(2);
      burst(3);
    join
    chk_grant = 1'b0;
    check("t2_grants_seen", 128'(grant_q.size()), 128'(0));
    wait_drain(30);

    // Slave 2 silent: four reads fill its FIFO, write still passes, fifth read stalls.
    resp_en[2] = 1'b0;
    for (int k = 0; k < 4; k++) master_xfer(1, 32'h8000_0000 + AW'(k * 4), 1'b0, '0);
    start_req(1, 32'h8000_1000, 1'b1, 32'h1234_5678);
    @(negedge clk);
    check("t3_wr_cmd", 128'(s_cmd[2]), 128'(1));
    check("t3_wr_data", 128'(s_wdata[2]), 128'(32'h1234_5678));
    wait_ack(1, 10);
    start_req(1, 32'h8000_0040, 1'b0, '0);
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      seen |= m_ack[1] | s_req[2];
    end
    check("t3_full_stall", 128'(seen), 128'(0));
    @(posedge clk);
    #1;
    resp_en[2] = 1'b1;
    wait_ack(1, 20);
    wait_drain(30);

    // Ordering: read to slave 3 held while a slave-0 read is outstanding.
    resp_en[0] = 1'b0;
    master_xfer(0, 32'h0000_0020, 1'b0, '0);
    start_req(0, 32'hC000_0040, 1'b0, '0);
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      seen |= m_ack[0] | s_req[3];
    end
    check("t4_order_hold", 128'(seen), 128'(0));
    @(posedge clk);
    #1;
    resp_en[0] = 1'b1;
    wait_ack(0, 20);
    wait_drain(30);

    // Two slaves answer two masters in the same cycle.
    resp_en[0] = 1'b0;
    resp_en[1] = 1'b0;
    fork
      master_xfer(2, 32'h0000_0100, 1'b0, '0);
      master_xfer(3, 32'h4000_0200, 1'b0, '0);
    join
    resp_en[0] = 1'b1;
    resp_en[1] = 1'b1;
    @(negedge clk);
    check("t5_dual_resp", 128'(m_resp), 128'(4'b1100));
    wait_drain(20);

    // Asynchronous reset with three reads outstanding and one request stalled.
    resp_en[2] = 1'b0;
    for (int k = 0; k < 3; k++) master_xfer(1, 32'h8000_0100 + AW'(k * 4), 1'b0, '0);
    ack_lat[2] = 3;
    start_req(0, 32'h8000_0200, 1'b0, '0);
    @(negedge clk);
    check("t6_inflight", 128'(s_req[2]), 128'(1));
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_s_req", 128'(s_req), 128'(0));
    check("t6_m_ack", 128'(m_ack), 128'(0));
    check("t6_m_resp", 128'(m_resp), 128'(0));
    check("t6_s_addr", 128'(s_addr), 128'(0));
    check("t6_s_cmd", 128'(s_cmd), 128'(0));
    check("t6_m_rdata", 128'(m_rdata), 128'(0));
    m_req = '0;
    for (int m = 0; m < NM; m++) exp_q[m].delete();
    ack_lat[2] = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    master_xfer(1, 32'hC000_0010, 1'b0, '0);
    wait_drain(20);
    for (int k = 0; k < 4; k++) master_xfer(0, 32'h8000_0400 + AW'(k * 4), 1'b0, '0);
    resp_en[2] = 1'b1;
    wait_drain(30);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
